// File: rtl/hack_rom_loader_pkg.sv
// Shared types and constants for the Hack ROM loader.
package hack_pkg;

   localparam int unsigned HACK_WORD_W = 16;
   localparam int unsigned HACK_ROM_AW = 15;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      FLUSH,
      HOLD,
      RUN
   } state_t;

   // Ceiling log2 usable in constant expressions; clog2(0) and clog2(1) are 0.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/hack_rom_loader_if.sv
// IOCTL byte stream in, ROM word writes and CPU boot control out.
interface hack_rom_loader_if
   import hack_pkg::*;
#(
   parameter int unsigned WORD_W   = HACK_WORD_W,
   parameter int unsigned ROM_AW   = HACK_ROM_AW,
   parameter int unsigned IOCTL_AW = 16
) ();

   logic                ioctl_download;
   logic                ioctl_wr;
   logic [IOCTL_AW-1:0] ioctl_addr;
   logic [7:0]          ioctl_din;
   logic                rom_we;
   logic [ROM_AW-1:0]   rom_waddr;
   logic [WORD_W-1:0]   rom_wdata;
   logic                cpu_reset;
   logic                busy;
   logic [ROM_AW:0]     words_loaded;
   logic                load_error;

   // HPS / system side
   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_din,
      input  rom_we, rom_waddr, rom_wdata, cpu_reset, busy, words_loaded, load_error
   );

   // Loader side
   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_din,
      output rom_we, rom_waddr, rom_wdata, cpu_reset, busy, words_loaded, load_error
   );

endinterface

// File: rtl/hack_rom_loader_assembler.sv
// Collects bytes into a ROM word by lane and emits the word when complete or flushed.
module hack_byte_assembler
   import hack_pkg::*;
#(
   parameter int unsigned WORD_W     = HACK_WORD_W,
   parameter int unsigned ROM_AW     = HACK_ROM_AW,
   parameter bit          BIG_ENDIAN = 1'b0,
   localparam int unsigned BPW       = WORD_W / 8,
   localparam int unsigned LW        = (clog2(BPW) > 0) ? clog2(BPW) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [LW-1:0]     lane,
   input  logic [ROM_AW-1:0] word_idx,
   input  logic [7:0]        din,
   output logic              emit_c,
   output logic              mismatch_c,
   output logic              pending_c,
   output logic              rom_we,
   output logic [ROM_AW-1:0] rom_waddr,
   output logic [WORD_W-1:0] rom_wdata
);

   logic [WORD_W-1:0] asm_q, asm_b, asm_n;
   logic [BPW-1:0]    mask_q, mask_b, mask_n;
   logic [ROM_AW-1:0] idx_q, idx_n;
   logic              complete_c;

   // Merge this cycle's byte into the pending word; a foreign word index drops the partial word
   always_comb begin
      asm_b      = clear ? '0 : asm_q;
      mask_b     = clear ? '0 : mask_q;
      idx_n      = idx_q;
      mismatch_c = 1'b0;
      complete_c = 1'b0;
      if (wr_en && (mask_b != '0) && (word_idx != idx_q)) begin
         mismatch_c = 1'b1;
         asm_b      = '0;
         mask_b     = '0;
      end
      asm_n  = asm_b;
      mask_n = mask_b;
      if (wr_en) begin
         for (int unsigned i = 0; i < BPW; i++) begin
            if (lane == LW'(i)) begin
               asm_n[8*(BIG_ENDIAN ? (BPW - 1 - i) : i) +: 8] = din;
               mask_n[i] = 1'b1;
            end
         end
         idx_n      = word_idx;
         complete_c = (lane == LW'(BPW - 1));
      end
      emit_c    = complete_c || (flush && (mask_q != '0));
      pending_c = (mask_n != '0) && !complete_c;
   end

   // Assembly state and the registered ROM write port
   always_ff @(posedge clk) begin
      if (reset) begin
         asm_q     <= '0;
         mask_q    <= '0;
         idx_q     <= '0;
         rom_we    <= 1'b0;
         rom_waddr <= '0;
         rom_wdata <= '0;
      end else begin
         rom_we <= emit_c;
         if (complete_c) begin
            rom_waddr <= idx_n;
            rom_wdata <= asm_n;
         end else if (emit_c) begin
            rom_waddr <= idx_q;
            rom_wdata <= asm_q;
         end
         if (emit_c) begin
            asm_q  <= '0;
            mask_q <= '0;
         end else begin
            asm_q  <= asm_n;
            mask_q <= mask_n;
         end
         idx_q <= idx_n;
      end
   end

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader: IOCTL bytes -> ROM words, with CPU reset sequencing around the download.
module hack_rom_loader
   import hack_pkg::*;
#(
   parameter int unsigned WORD_W      = HACK_WORD_W,
   parameter int unsigned ROM_AW      = HACK_ROM_AW,
   parameter int unsigned IOCTL_AW    = 16,
   parameter bit          BIG_ENDIAN  = 1'b0,
   parameter int unsigned HOLD_CYCLES = 4
) (
   input logic              clk,
   input logic              reset,
   hack_rom_loader_if.slave bus
);

   localparam int unsigned BPW = WORD_W / 8;
   localparam int unsigned LW  = (clog2(BPW) > 0) ? clog2(BPW) : 1;
   localparam int unsigned CW  = (clog2(HOLD_CYCLES + 1) > 0) ? clog2(HOLD_CYCLES + 1) : 1;
   localparam int unsigned NW  = ROM_AW + 1;
   localparam logic [NW-1:0] WORDS_MAX = NW'(1) << ROM_AW;

   state_t              state_q, state_d;
   logic                dl_q;
   logic                dl_rise_c, dl_fall_c, accept_c, in_range_c, wr_en_c, flush_c;
   logic [IOCTL_AW-1:0] word_full_c;
   logic [LW-1:0]       lane_c;
   logic [CW-1:0]       hold_q;
   logic                emit_c, mismatch_c, pending_c;
   logic                cpu_reset_q, busy_q, load_error_q;
   logic [NW-1:0]       words_q;
   logic                rom_we;
   logic [ROM_AW-1:0]   rom_waddr;
   logic [WORD_W-1:0]   rom_wdata;

   // Address split, download edge detection and byte acceptance
   always_comb begin
      lane_c      = LW'(bus.ioctl_addr % IOCTL_AW'(BPW));
      word_full_c = bus.ioctl_addr / IOCTL_AW'(BPW);
      in_range_c  = (word_full_c >> ROM_AW) == '0;
      dl_rise_c   = bus.ioctl_download && !dl_q;
      dl_fall_c   = !bus.ioctl_download && dl_q;
      accept_c    = bus.ioctl_wr && ((state_q == LOAD) || dl_rise_c);
      wr_en_c     = accept_c && in_range_c;
      flush_c     = (state_q == FLUSH) && !dl_rise_c;
   end

   hack_byte_assembler #(
      .WORD_W     (WORD_W),
      .ROM_AW     (ROM_AW),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_asm (
      .clk        (clk),
      .reset      (reset),
      .clear      (dl_rise_c),
      .flush      (flush_c),
      .wr_en      (wr_en_c),
      .lane       (lane_c),
      .word_idx   (ROM_AW'(word_full_c)),
      .din        (bus.ioctl_din),
      .emit_c     (emit_c),
      .mismatch_c (mismatch_c),
      .pending_c  (pending_c),
      .rom_we     (rom_we),
      .rom_waddr  (rom_waddr),
      .rom_wdata  (rom_wdata)
   );

   // Next-state logic; a new download start wins from any state
   always_comb begin
      state_d = state_q;
      if (dl_rise_c) begin
         state_d = LOAD;
      end else begin
         case (state_q)
            IDLE:    state_d = HOLD;
            LOAD:    if (dl_fall_c) state_d = pending_c ? FLUSH : HOLD;
            FLUSH:   state_d = HOLD;
            HOLD:    if (hold_q <= CW'(1)) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = HOLD;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= HOLD;
      else       state_q <= state_d;
   end

   // Hold countdown, download edge tracking and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         dl_q         <= 1'b0;
         hold_q       <= CW'(HOLD_CYCLES);
         cpu_reset_q  <= 1'b1;
         busy_q       <= 1'b1;
         words_q      <= '0;
         load_error_q <= 1'b0;
      end else begin
         dl_q <= bus.ioctl_download;
         if ((state_d == HOLD) && (state_q != HOLD)) hold_q <= CW'(HOLD_CYCLES);
         else if (state_q == HOLD)                   hold_q <= hold_q - CW'(1);
         cpu_reset_q <= (state_d != RUN);
         busy_q      <= (state_d != RUN);
         if (dl_rise_c)                              words_q <= emit_c ? NW'(1) : '0;
         else if (emit_c && (words_q != WORDS_MAX))  words_q <= words_q + NW'(1);
         load_error_q <= (load_error_q && !dl_rise_c) || mismatch_c || (accept_c && !in_range_c);
      end
   end

   assign bus.rom_we       = rom_we;
   assign bus.rom_waddr    = rom_waddr;
   assign bus.rom_wdata    = rom_wdata;
   assign bus.cpu_reset    = cpu_reset_q;
   assign bus.busy         = busy_q;
   assign bus.words_loaded = words_q;
   assign bus.load_error   = load_error_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: little- and big-endian instances share one IOCTL stream.
module tb_hack_rom_loader;

   logic        clk;
   logic        reset;
   logic        download;
   logic        wr;
   logic [16:0] addr;
   logic [7:0]  din;

   hack_rom_loader_if #(.WORD_W(16), .ROM_AW(15), .IOCTL_AW(17)) bus_le ();
   hack_rom_loader_if #(.WORD_W(16), .ROM_AW(15), .IOCTL_AW(17)) bus_be ();

   assign bus_le.ioctl_download = download;
   assign bus_le.ioctl_wr       = wr;
   assign bus_le.ioctl_addr     = addr;
   assign bus_le.ioctl_din      = din;
   assign bus_be.ioctl_download = download;
   assign bus_be.ioctl_wr       = wr;
   assign bus_be.ioctl_addr     = addr;
   assign bus_be.ioctl_din      = din;

   hack_rom_loader #(.WORD_W(16), .ROM_AW(15), .IOCTL_AW(17), .BIG_ENDIAN(1'b0), .HOLD_CYCLES(4))
      u_le (.clk(clk), .reset(reset), .bus(bus_le));
   hack_rom_loader #(.WORD_W(16), .ROM_AW(15), .IOCTL_AW(17), .BIG_ENDIAN(1'b1), .HOLD_CYCLES(4))
      u_be (.clk(clk), .reset(reset), .bus(bus_be));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;

   // Observed writes as {addr, data}
   logic [30:0] mon_le[$];
   logic [30:0] mon_be[$];

   always @(negedge clk) begin
      if (bus_le.rom_we) mon_le.push_back({bus_le.rom_waddr, bus_le.rom_wdata});
      if (bus_be.rom_we) mon_be.push_back({bus_be.rom_waddr, bus_be.rom_wdata});
   end

   // Transaction-level reference: byte lanes per word, expected write lists
   logic [7:0]  m_lane[2];
   bit          m_val[2];
   int          m_idx;
   bit          m_err;
   int          m_cnt;
   logic [30:0] exp_le[$];
   logic [30:0] exp_be[$];

   typedef struct {
      logic [16:0] addr;
      logic [7:0]  din;
      logic        we;
      logic [14:0] waddr;
      logic [15:0] le;
      logic [15:0] be;
   } vec_t;

   vec_t tab[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_clear_word();
      m_lane[0] = 8'h00;
      m_lane[1] = 8'h00;
      m_val[0]  = 1'b0;
      m_val[1]  = 1'b0;
   endtask

   task automatic model_start();
      model_clear_word();
      m_err = 1'b0;
      m_cnt = 0;
      exp_le.delete();
      exp_be.delete();
   endtask

   task automatic model_emit();
      exp_le.push_back({15'(m_idx), m_lane[1], m_lane[0]});
      exp_be.push_back({15'(m_idx), m_lane[0], m_lane[1]});
      if (m_cnt < 32768) m_cnt++;
      model_clear_word();
   endtask

   task automatic model_byte(input int a, input logic [7:0] d);
      int w;
      int l;
      w = a / 2;
      l = a % 2;
      if (w >= 32768) begin
         m_err = 1'b1;
      end else begin
         if ((m_val[0] || m_val[1]) && (w != m_idx)) begin
            m_err = 1'b1;
            model_clear_word();
         end
         m_lane[l] = d;
         m_val[l]  = 1'b1;
         m_idx     = w;
         if (l == 1) model_emit();
      end
   endtask

   task automatic model_end();
      if (m_val[0] || m_val[1]) model_emit();
   endtask

   task automatic drive_byte(input logic [16:0] a, input logic [7:0] d);
      wr   = 1'b1;
      addr = a;
      din  = d;
      @(negedge clk);
      wr   = 1'b0;
   endtask

   task automatic start_dl();
      mon_le.delete();
      mon_be.delete();
      download = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while ((bus_le.cpu_reset || bus_be.cpu_reset) && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      chk("run_reached", 32'(bus_le.cpu_reset || bus_be.cpu_reset), 32'd0);
   endtask

   task automatic count_hold(input string name);
      int ones;
      ones = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus_le.cpu_reset) ones++;
         @(negedge clk);
      end
      chk(name, 32'(ones), 32'd4);
      chk({name, "_busy"}, 32'(bus_le.busy), 32'd0);
   endtask

   task automatic run_table(input int n);
      start_dl();
      for (int i = 0; i < n; i++) begin
         drive_byte(tab[i].addr, tab[i].din);
         chk("tab_we_le", 32'(bus_le.rom_we), 32'(tab[i].we));
         chk("tab_we_be", 32'(bus_be.rom_we), 32'(tab[i].we));
         if (tab[i].we) begin
            chk("tab_waddr", 32'(bus_le.rom_waddr), 32'(tab[i].waddr));
            chk("tab_wdata_le", 32'(bus_le.rom_wdata), 32'(tab[i].le));
            chk("tab_wdata_be", 32'(bus_be.rom_wdata), 32'(tab[i].be));
         end
      end
      download = 1'b0;
      wait_run();
      chk("tab_words", 32'(bus_le.words_loaded), 32'(n / 2));
      chk("tab_err", 32'(bus_le.load_error), 32'd0);
   endtask

   task automatic compare_dl();
      int n;
      chk("rnd_nwr_le", 32'(mon_le.size()), 32'(exp_le.size()));
      chk("rnd_nwr_be", 32'(mon_be.size()), 32'(exp_be.size()));
      n = (mon_le.size() < exp_le.size()) ? mon_le.size() : exp_le.size();
      for (int i = 0; i < n; i++) chk("rnd_wr_le", 32'(mon_le[i]), 32'(exp_le[i]));
      n = (mon_be.size() < exp_be.size()) ? mon_be.size() : exp_be.size();
      for (int i = 0; i < n; i++) chk("rnd_wr_be", 32'(mon_be[i]), 32'(exp_be[i]));
      chk("rnd_words_le", 32'(bus_le.words_loaded), 32'(m_cnt));
      chk("rnd_words_be", 32'(bus_be.words_loaded), 32'(m_cnt));
      chk("rnd_err_le", 32'(bus_le.load_error), 32'(m_err));
      chk("rnd_err_be", 32'(bus_be.load_error), 32'(m_err));
   endtask

   task automatic rand_dl();
      int          a;
      int          nb;
      int          r;
      logic [7:0]  d;
      model_start();
      start_dl();
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(32'h0FFF8, 32'h10002));
      else                           a = int'($urandom_range(0, 64));
      nb = int'($urandom_range(1, 12));
      for (int i = 0; i < nb; i++) begin
         d = 8'($urandom);
         model_byte(a, d);
         drive_byte(17'(a), d);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         r = int'($urandom_range(0, 9));
         if (r == 0)      a = int'($urandom_range(0, 32'h1FFFF));
         else if (r == 1) a = a + 2;
         else if (r != 2) a = a + 1;
         if (a > 32'h1FFFF) a = 0;
      end
      download = 1'b0;
      model_end();
      wait_run();
      compare_dl();
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      reset    = 1'b1;
      download = 1'b0;
      wr       = 1'b0;
      addr     = '0;
      din      = '0;

      tab[0] = '{17'h0, 8'h34, 1'b0, 15'h0, 16'h0000, 16'h0000};
      tab[1] = '{17'h1, 8'h12, 1'b1, 15'h0, 16'h1234, 16'h3412};
      tab[2] = '{17'h2, 8'hCD, 1'b0, 15'h0, 16'h0000, 16'h0000};
      tab[3] = '{17'h3, 8'hAB, 1'b1, 15'h1, 16'hABCD, 16'hCDAB};
      tab[4] = '{17'h4, 8'h5A, 1'b0, 15'h0, 16'h0000, 16'h0000};
      tab[5] = '{17'h5, 8'hA5, 1'b1, 15'h2, 16'hA55A, 16'h5AA5};
      tab[6] = '{17'h6, 8'h0F, 1'b0, 15'h0, 16'h0000, 16'h0000};
      tab[7] = '{17'h7, 8'hF0, 1'b1, 15'h3, 16'hF00F, 16'h0FF0};

      // Reset values, then the post-reset hold length
      repeat (2) @(negedge clk);
      chk("rst_cpu_reset", 32'(bus_le.cpu_reset), 32'd1);
      chk("rst_busy", 32'(bus_le.busy), 32'd1);
      chk("rst_rom_we", 32'(bus_le.rom_we), 32'd0);
      chk("rst_waddr", 32'(bus_le.rom_waddr), 32'd0);
      chk("rst_wdata", 32'(bus_le.rom_wdata), 32'd0);
      chk("rst_words", 32'(bus_le.words_loaded), 32'd0);
      chk("rst_err", 32'(bus_le.load_error), 32'd0);
      chk("rst_be_cpu_reset", 32'(bus_be.cpu_reset), 32'd1);
      reset = 1'b0;
      count_hold("rst_hold");

      // Four-byte download, both byte orders
      run_table(4);

      // Odd byte count: the third byte is flushed after download falls
      start_dl();
      drive_byte(17'h0, 8'h01);
      drive_byte(17'h1, 8'h02);
      chk("odd_we0", 32'(bus_le.rom_we), 32'd1);
      chk("odd_data0", 32'(bus_le.rom_wdata), 32'h0201);
      drive_byte(17'h2, 8'h03);
      download = 1'b0;
      @(negedge clk);
      chk("flush_pre_we", 32'(bus_le.rom_we), 32'd0);
      chk("flush_pre_cpu_reset", 32'(bus_le.cpu_reset), 32'd1);
      @(negedge clk);
      chk("flush_we", 32'(bus_le.rom_we), 32'd1);
      chk("flush_waddr", 32'(bus_le.rom_waddr), 32'd1);
      chk("flush_data_le", 32'(bus_le.rom_wdata), 32'h0003);
      chk("flush_data_be", 32'(bus_be.rom_wdata), 32'h0300);
      chk("flush_words", 32'(bus_le.words_loaded), 32'd2);
      count_hold("flush_hold");

      // Word-index mismatch: partial word 0 dropped, word 2 flushed
      start_dl();
      drive_byte(17'h0, 8'h11);
      chk("mm_we0", 32'(bus_le.rom_we), 32'd0);
      drive_byte(17'h4, 8'h22);
      chk("mm_err", 32'(bus_le.load_error), 32'd1);
      chk("mm_we1", 32'(bus_le.rom_we), 32'd0);
      download = 1'b0;
      wait_run();
      chk("mm_nwr", 32'(mon_le.size()), 32'd1);
      if (mon_le.size() > 0) chk("mm_wr_le", 32'(mon_le[0]), {1'b0, 15'd2, 16'h0022});
      if (mon_be.size() > 0) chk("mm_wr_be", 32'(mon_be[0]), {1'b0, 15'd2, 16'h2200});
      chk("mm_words", 32'(bus_le.words_loaded), 32'd1);
      chk("mm_err_kept", 32'(bus_le.load_error), 32'd1);

      // New download from RUN clears status and reasserts cpu_reset at once
      download = 1'b1;
      @(negedge clk);
      chk("restart_cpu_reset", 32'(bus_le.cpu_reset), 32'd1);
      chk("restart_busy", 32'(bus_le.busy), 32'd1);
      chk("restart_words", 32'(bus_le.words_loaded), 32'd0);
      chk("restart_err", 32'(bus_le.load_error), 32'd0);
      download = 1'b0;
      wait_run();

      // Top ROM word accepted, first word beyond the ROM dropped
      start_dl();
      drive_byte(17'h0FFFE, 8'h77);
      drive_byte(17'h0FFFF, 8'h88);
      chk("top_we", 32'(bus_le.rom_we), 32'd1);
      chk("top_waddr", 32'(bus_le.rom_waddr), 32'h7FFF);
      chk("top_data_le", 32'(bus_le.rom_wdata), 32'h8877);
      chk("top_data_be", 32'(bus_be.rom_wdata), 32'h7788);
      drive_byte(17'h10000, 8'h55);
      chk("oor_we", 32'(bus_le.rom_we), 32'd0);
      chk("oor_err", 32'(bus_le.load_error), 32'd1);
      download = 1'b0;
      wait_run();
      chk("oor_nwr", 32'(mon_le.size()), 32'd1);
      chk("oor_words", 32'(bus_le.words_loaded), 32'd1);

      // Back-to-back bytes on eight consecutive cycles
      run_table(8);

      // Reset in the middle of a word writes nothing
      start_dl();
      drive_byte(17'h0, 8'h99);
      reset    = 1'b1;
      download = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      wait_run();
      chk("mid_rst_nwr", 32'(mon_le.size() + mon_be.size()), 32'd0);
      chk("mid_rst_words", 32'(bus_le.words_loaded), 32'd0);
      chk("mid_rst_err", 32'(bus_le.load_error), 32'd0);

      // Randomised downloads against the reference model
      for (int t = 0; t < 40; t++) rand_dl();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
